// File: rtl/countdown_ctrl.sv
// Sequencing controller for the BCD mm:ss countdown: mode, load strobe, preset, 1 Hz tick, alarm.
// Define AUTO_RELOAD_EN to reload the preset and restart automatically when the alarm expires.
module countdown_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic       btn_clear,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min0,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    output logic [1:0] alu,
    output logic       switch,
    output logic [3:0] in_min1,
    output logic [3:0] in_min0,
    output logic [3:0] in_sec1,
    output logic [3:0] in_sec0,
    output logic       tick,
    output logic       alarm,
    output logic [2:0] state
);
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int ACNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? 4'd0 : d;
    endfunction

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [ACNT_W-1:0]   acnt_q, acnt_d;
    logic [15:0]         preset_q, preset_d;
    logic [15:0]         preset_clamped;
    logic [1:0]          alu_d;
    logic                switch_d, tick_d, alarm_d;
    logic                cnt_zero, div_hit;
`ifdef AUTO_RELOAD_EN
    logic                reload_q, reload_d;
`endif

    assign preset_clamped = {clamp_digit(set_min1, 4'd5), clamp_digit(set_min0, 4'd9),
                             clamp_digit(set_sec1, 4'd5), clamp_digit(set_sec0, 4'd9)};
    assign cnt_zero = ({min1, min0, sec1, sec0} == 16'h0000);
    assign div_hit  = (div_q == DIV_LAST);

    assign {in_min1, in_min0, in_sec1, in_sec0} = preset_q;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            acnt_q   <= '0;
            preset_q <= '0;
            alu      <= 2'b00;
            switch   <= 1'b0;
            tick     <= 1'b0;
            alarm    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            acnt_q   <= acnt_d;
            preset_q <= preset_d;
            alu      <= alu_d;
            switch   <= switch_d;
            tick     <= tick_d;
            alarm    <= alarm_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Outputs are computed as next-cycle values so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        acnt_d   = '0;
        preset_d = preset_q;
        alu_d    = 2'b00;
        switch_d = 1'b0;
        tick_d   = 1'b0;
        alarm_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (btn_load) begin
                    state_d  = S_LOAD;
                    switch_d = 1'b1;
                    preset_d = preset_clamped;
                end
            end
            S_LOAD: begin
                state_d = (preset_q == 16'h0000) ? S_IDLE : S_READY;
`ifdef AUTO_RELOAD_EN
                if (reload_q) begin
                    state_d  = S_RUN;
                    alu_d    = 2'b01;
                    reload_d = 1'b0;
                end
`endif
            end
            S_READY, S_PAUSE: begin
                if (btn_load) begin
                    state_d  = S_LOAD;
                    switch_d = 1'b1;
                    preset_d = preset_clamped;
                end else if (btn_start) begin
                    state_d = S_RUN;
                    alu_d   = 2'b01;
                end
            end
            S_RUN: begin
                if (btn_start) begin
                    state_d = S_PAUSE;
                end else begin
                    alu_d = 2'b01;
                    // Terminal count swallows the tick so the counters never wrap to 59:59.
                    if (div_hit) begin
                        if (cnt_zero) begin
                            state_d = S_DONE;
                            alu_d   = 2'b00;
                            alarm_d = 1'b1;
                        end else begin
                            tick_d = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                alarm_d = 1'b1;
                if (btn_start) begin
                    state_d = S_IDLE;
                    alarm_d = 1'b0;
                end else if (div_hit) begin
                    if (acnt_q == ACNT_LAST) begin
                        alarm_d = 1'b0;
`ifdef AUTO_RELOAD_EN
                        state_d  = S_LOAD;
                        switch_d = 1'b1;
                        reload_d = 1'b1;
`else
                        state_d  = S_IDLE;
`endif
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end else begin
                    div_d  = div_q + 1'b1;
                    acnt_d = acnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (btn_clear) begin
            state_d  = S_IDLE;
            div_d    = '0;
            acnt_d   = '0;
            preset_d = preset_q;
            alu_d    = 2'b00;
            switch_d = 1'b0;
            tick_d   = 1'b0;
            alarm_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_d = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized self-checking bench for countdown_ctrl with a behavioural mm:ss counter model.
// Expectations follow AUTO_RELOAD_EN when the bench is built with it defined.
module tb_countdown_ctrl;
    localparam int TD = 4;
    localparam int AT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
    logic [3:0] set_min1 = '0, set_min0 = '0, set_sec1 = '0, set_sec0 = '0;
    logic [3:0] min1, min0, sec1, sec0;
    logic [1:0] alu;
    logic       switch, tick, alarm;
    logic [3:0] in_min1, in_min0, in_sec1, in_sec0;
    logic [2:0] state;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    int c_min = 0, c_sec = 0;
    int pre_min = 0, pre_sec = 0;

    countdown_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_load(btn_load), .btn_clear(btn_clear),
        .set_min1(set_min1), .set_min0(set_min0), .set_sec1(set_sec1), .set_sec0(set_sec0),
        .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
        .alu(alu), .switch(switch),
        .in_min1(in_min1), .in_min0(in_min0), .in_sec1(in_sec1), .in_sec0(in_sec0),
        .tick(tick), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural down_minute/down_second pair: loads on switch, decrements on enabled tick.
    always @(posedge clk) begin
        if (switch) begin
            c_min <= pre_min;
            c_sec <= pre_sec;
        end else if (tick && alu == 2'b01) begin
            if (c_sec > 0) c_sec <= c_sec - 1;
            else if (c_min > 0) begin
                c_min <= c_min - 1;
                c_sec <= 59;
            end
        end
    end

    assign min1 = 4'(c_min / 10);
    assign min0 = 4'(c_min % 10);
    assign sec1 = 4'(c_sec / 10);
    assign sec0 = 4'(c_sec % 10);
    assign obs  = {state, alu, switch, tick, alarm};

    function automatic int cl(input int d, input int lim);
        return (d > lim) ? 0 : d;
    endfunction

    function automatic logic [7:0] ev(input int st, input int a, input bit sw, input bit tk, input bit al);
        return {3'(st), 2'(a), sw, tk, al};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        btn_start = s;
        btn_load  = l;
        btn_clear = c;
        step();
        btn_start = 1'b0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic do_load(input int m1, input int m0, input int s1, input int s0);
        set_min1 = 4'(m1);
        set_min0 = 4'(m0);
        set_sec1 = 4'(s1);
        set_sec0 = 4'(s0);
        pre_min  = cl(m1, 5) * 10 + cl(m0, 9);
        pre_sec  = cl(s1, 5) * 10 + cl(s0, 9);
        press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, ev(0, 0, 0, 0, 0));
        end
        checks++;
        if ({in_min1, in_min0, in_sec1, in_sec0} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_preset: got %h expected 0000", {in_min1, in_min0, in_sec1, in_sec0});
        end
        rst = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== ev(0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL idle_ignores_start k=%0d: got %b expected %b", k, obs, ev(0, 0, 0, 0, 0));
            end
            step();
        end
    endtask

    task automatic test_load();
        do_load(0, 1, 3, 0);
        checks++;
        if (obs !== ev(1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL load_entry: got %b expected %b", obs, ev(1, 0, 1, 0, 0));
        end
        checks++;
        if ({in_min1, in_min0, in_sec1, in_sec0} !== 16'h0130) begin
            errors++;
            $display("FAIL load_preset: got %h expected 0130", {in_min1, in_min0, in_sec1, in_sec0});
        end
        step();
        checks++;
        if (obs !== ev(2, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL load_to_ready: got %b expected %b", obs, ev(2, 0, 0, 0, 0));
        end
        step();
        checks++;
        if (obs !== ev(2, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL ready_hold: got %b expected %b", obs, ev(2, 0, 0, 0, 0));
        end
        press(1'b0, 1'b0, 1'b1);
        do_load(0, 0, 0, 0);
        step();
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_preset_idle: got %b expected %b", obs, ev(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_clamp();
        int d[4];
        logic [15:0] e;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                d[0] = 0; d[1] = 2; d[2] = 7; d[3] = 12;
            end else begin
                for (int j = 0; j < 4; j++) d[j] = $urandom_range(0, 15);
            end
            do_load(d[0], d[1], d[2], d[3]);
            e = {4'(cl(d[0], 5)), 4'(cl(d[1], 9)), 4'(cl(d[2], 5)), 4'(cl(d[3], 9))};
            checks++;
            if ({in_min1, in_min0, in_sec1, in_sec0} !== e) begin
                errors++;
                $display("FAIL clamp i=%0d: got %h expected %h", i, {in_min1, in_min0, in_sec1, in_sec0}, e);
            end
            step();
            checks++;
            if (state !== ((pre_min * 60 + pre_sec == 0) ? 3'd0 : 3'd2)) begin
                errors++;
                $display("FAIL clamp_state i=%0d: got %0d expected %0d", i, state,
                         (pre_min * 60 + pre_sec == 0) ? 0 : 2);
            end
            press(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_run_pause();
        int n1;
        do_load(0, 0, 5, 9);
        step();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== ev(3, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL run_entry: got %b expected %b", obs, ev(3, 1, 0, 0, 0));
        end
        n1 = $urandom_range(5, 14);
        for (int k = 1; k <= n1; k++) begin
            step();
            checks++;
            if (obs !== ev(3, 1, 0, (k % TD == 0), 0)) begin
                errors++;
                $display("FAIL run_tick k=%0d: got %b expected %b", k, obs, ev(3, 1, 0, (k % TD == 0), 0));
            end
        end
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 21; k++) begin
            checks++;
            if (obs !== ev(4, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL pause_hold k=%0d: got %b expected %b", k, obs, ev(4, 0, 0, 0, 0));
            end
            step();
        end
        press(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 2 * TD + 1; k++) begin
            step();
            checks++;
            if (obs !== ev(3, 1, 0, (k % TD == 0), 0)) begin
                errors++;
                $display("FAIL resume_tick k=%0d: got %b expected %b", k, obs, ev(3, 1, 0, (k % TD == 0), 0));
            end
        end
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_terminal(input int secs);
        int kd;
        logic [7:0] e;
        do_load((secs / 60) / 10, (secs / 60) % 10, (secs % 60) / 10, (secs % 60) % 10);
        step();
        press(1'b1, 1'b0, 1'b0);
        kd = TD * (secs + 1);
        for (int k = 1; k <= kd + TD * AT; k++) begin
            step();
            if (k < kd) e = ev(3, 1, 0, (k % TD == 0), 0);
            else if (k < kd + TD * AT) e = ev(5, 0, 0, 0, 1);
`ifdef AUTO_RELOAD_EN
            else e = ev(1, 0, 1, 0, 0);
`else
            else e = ev(0, 0, 0, 0, 0);
`endif
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL terminal secs=%0d k=%0d: got %b expected %b", secs, k, obs, e);
            end
        end
`ifdef AUTO_RELOAD_EN
        for (int k = 1; k <= TD + 1; k++) begin
            step();
            checks++;
            if (obs !== ev(3, 1, 0, (k == TD + 1), 0)) begin
                errors++;
                $display("FAIL auto_reload k=%0d: got %b expected %b", k, obs, ev(3, 1, 0, (k == TD + 1), 0));
            end
        end
`endif
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_priority();
        do_load(0, 0, 3, 0);
        step();
        press(1'b1, 1'b0, 1'b0);
        repeat (5) step();
        press(1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL clear_over_start: got %b expected %b", obs, ev(0, 0, 0, 0, 0));
        end
        do_load(0, 0, 3, 0);
        step();
        press(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== ev(1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL pause_load_wins: got %b expected %b", obs, ev(1, 0, 1, 0, 0));
        end
        step();
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== ev(1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL ready_load_wins: got %b expected %b", obs, ev(1, 0, 1, 0, 0));
        end
        press(1'b0, 1'b0, 1'b1);
        do_load(0, 0, 0, 1);
        step();
        press(1'b1, 1'b0, 1'b0);
        repeat (2 * TD) step();
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL done_start_wins: got %b expected %b", obs, ev(0, 0, 0, 0, 0));
        end
        do_load(0, 0, 0, 1);
        step();
        press(1'b1, 1'b0, 1'b0);
        repeat (2 * TD + 1) step();
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL done_clear: got %b expected %b", obs, ev(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        do_load(0, 0, 2, 0);
        step();
        press(1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(2, 9)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0) || {in_min1, in_min0, in_sec1, in_sec0} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: got %b/%h expected %b/0000", obs,
                     {in_min1, in_min0, in_sec1, in_sec0}, ev(0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_clamp();
        test_run_pause();
        test_terminal($urandom_range(1, 5));
        test_terminal($urandom_range(1, 5));
        test_terminal(60);
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the BCD minute/second countdown datapath: generates the counter mode (alu), the load strobe (switch), the preset values and the 1 Hz count-enable tick.
- Sits between the debounced one-pulse buttons and the down_second/down_minute counters.
- Detects terminal count (00:00) and drives the alarm.

Parameters:
- TICK_DIV, 100000000, system clocks per count tick (1 Hz at 100 MHz); minimum 2.
- ALARM_TICKS, 10, ticks the alarm stays high in DONE before automatic return to IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_start  in  1  one-cycle pulse; toggles start/pause.
- btn_load  in  1  one-cycle pulse; loads the preset into the counters.
- btn_clear  in  1  one-cycle pulse; abort to IDLE.
- set_min1, set_min0, set_sec1, set_sec0  in  4 each  BCD preset from the switches.
- min1, min0, sec1, sec0  in  4 each  current counter values (BCD).
- alu  out  2  counter mode: 2'b00 hold, 2'b01 count down.
- switch  out  1  load strobe to the counters (1 = load in_* values).
- in_min1, in_min0, in_sec1, in_sec0  out  4 each  registered preset presented to the counters.
- tick  out  1  one-clk count-enable pulse, period TICK_DIV clocks.
- alarm  out  1  terminal-count indicator.
- state  out  3  current FSM state, for the display.

Behaviour:
- All outputs registered. Reset values: alu=00, switch=0, in_*=0, tick=0, alarm=0, state=IDLE, prescaler=0, alarm count=0.
- Preset clamp at capture: any set_* digit above 9 (set_sec1/set_min1 above 5) loads as 0.
- Prescaler:
  - Runs only in RUN. Cleared on entering RUN and in every other state.
  - tick=1 for one clk when the prescaler reaches TICK_DIV-1, then wraps to 0.
  - First tick after start comes exactly TICK_DIV clocks after the start pulse.
- States and encodings: IDLE=0, LOAD=1, READY=2, RUN=3, PAUSE=4, DONE=5.
- IDLE: alu=00, switch=0. btn_load -> LOAD. btn_start is ignored.
- LOAD:
  - Single-cycle state.
  - On entry cycle: in_* captures the clamped preset and switch=1.
  - Next cycle: switch=0, state=READY.
  - If the captured preset is 00:00, go to IDLE instead.
- READY: alu=00. btn_start -> RUN. btn_load -> LOAD (re-load).
- RUN:
  - alu=01.
  - When the counters read 00:00 on the clock a tick would issue, suppress that tick and go to DONE (no underflow to 59:59).
  - btn_start -> PAUSE.
- PAUSE: alu=00, prescaler held at 0. btn_start -> RUN. btn_load -> LOAD.
- DONE:
  - alu=00, alarm=1. The alarm counter uses an internal tick that keeps running in DONE.
  - After ALARM_TICKS internal ticks, or on btn_start, alarm=0 and state -> IDLE.
- Any state: btn_clear -> IDLE with alu=00, switch=0, alarm=0, prescaler and alarm count cleared. btn_clear has priority over all other buttons.
- Simultaneous btn_start and btn_load: btn_load wins in READY and PAUSE; btn_start wins in RUN and DONE.
- rst asserted mid-operation: all outputs return to their reset values on the next clock edge. Counter contents are not touched by this block.

Optional Feature:
- AUTO_RELOAD_EN defined: on leaving DONE via alarm expiry, go to LOAD (re-issue the latched in_* with switch=1), then directly to RUN, skipping READY. btn_start or btn_clear in DONE still go to IDLE.
- Undefined: DONE always exits to IDLE as specified above.

Test Plan:
- Reset/idle: rst high 2 cycles -> alu=00, switch=0, alarm=0, state=0. btn_start in IDLE -> state stays 0.
- Load: TICK_DIV=4, set=01:30, btn_load -> switch=1 for exactly 1 cycle, in_min1..in_sec0 = 0,1,3,0, then state=2. Set=00:00 -> back to state 0.
- Clamp: set_sec1=7, set_sec0=12 -> in_sec1=0, in_sec0=0.
- Run/pause: TICK_DIV=4, start -> first tick 4 clocks after the pulse, tick period 4. Pause -> alu=00, no ticks for 20 clocks. Start again -> first tick 4 clocks later.
- Terminal: model counters reaching 00:00 -> no further tick, state=5, alarm=1 for ALARM_TICKS=3 internal ticks (12 clocks), then state=0 (or LOAD then RUN with AUTO_RELOAD_EN).
- Priority: btn_clear together with btn_start in RUN -> state=0, alarm=0. btn_load with btn_start in PAUSE -> LOAD.
